// File: rtl/gate3_stim_chk.sv
// Exhaustive stimulus/checker for a 3-input gate: sweeps all input vectors,
// samples the gate output after a settle window and scores it against a truth table.
module gate3_stim_chk #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned NPASS      = 1,
  parameter logic [7:0]  EXPECT     = 8'h7F,
  parameter bit          GRAY       = 1'b1
) (
  input  logic       CLK,
  input  logic       RSTB,
  input  logic       START,
  output logic       DIN1,
  output logic       DIN2,
  output logic       DIN3,
  input  logic       QN_OBS,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_CNT,
  output logic [2:0] FAIL_VEC,
  output logic [7:0] TOG_CNT
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC);
  localparam logic [CW-1:0] PASS_LAST = CW'(NPASS - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    din_q, din_d;
  logic [2:0]    vidx_q, vidx_d;
  logic [CW-1:0] settle_q, settle_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic          prev_q, prev_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [3:0]    err_q, err_d;
  logic [2:0]    fvec_q, fvec_d;
  logic [7:0]    tog_q, tog_d;
  logic          mism_c;
  logic [3:0]    err_inc_c;
  logic [2:0]    vidx_nxt_c;

  // Sweep index to applied vector (reflected Gray code or plain binary)
  function automatic logic [2:0] vec_of(input logic [2:0] idx);
    if (GRAY) return idx ^ (idx >> 1);
    return idx;
  endfunction

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q  <= S_IDLE;
      din_q    <= 3'd0;
      vidx_q   <= 3'd0;
      settle_q <= '0;
      pcnt_q   <= '0;
      prev_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 4'd0;
      fvec_q   <= 3'd0;
      tog_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      vidx_q   <= vidx_d;
      settle_q <= settle_d;
      pcnt_q   <= pcnt_d;
      prev_q   <= prev_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fvec_q   <= fvec_d;
      tog_q    <= tog_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    vidx_d     = vidx_q;
    settle_d   = settle_q;
    pcnt_d     = pcnt_q;
    prev_d     = prev_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    fvec_d     = fvec_q;
    tog_d      = tog_q;
    mism_c     = (QN_OBS != EXPECT[din_q]);
    err_inc_c  = (err_q == 4'hF) ? 4'hF : 4'(err_q + 4'd1);
    vidx_nxt_c = 3'(vidx_q + 3'd1);

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d  = S_HOLD;
          vidx_d   = 3'd0;
          din_d    = vec_of(3'd0);
          busy_d   = 1'b1;
          settle_d = SETTLE_LD;
          pcnt_d   = '0;
          err_d    = 4'd0;
          fvec_d   = 3'd0;
          tog_d    = 8'd0;
          pass_d   = 1'b0;
          prev_d   = QN_OBS;
        end
      end
      S_HOLD: begin
        // Output activity is tracked on every busy edge, not only at samples
        prev_d = QN_OBS;
        if ((QN_OBS != prev_q) && (tog_q != 8'hFF)) tog_d = 8'(tog_q + 8'd1);
        if (settle_q != '0) begin
          settle_d = CW'(settle_q - 4'd1);
        end else begin
          if (mism_c) begin
            err_d = err_inc_c;
            if (err_q == 4'd0) fvec_d = din_q;
          end
          if (vidx_q != 3'd7) begin
            vidx_d   = vidx_nxt_c;
            din_d    = vec_of(vidx_nxt_c);
            settle_d = SETTLE_LD;
          end else if (pcnt_q < PASS_LAST) begin
            pcnt_d   = CW'(pcnt_q + 4'd1);
            vidx_d   = 3'd0;
            din_d    = vec_of(3'd0);
            settle_d = SETTLE_LD;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            din_d   = 3'd0;
            done_d  = 1'b1;
            pass_d  = !mism_c && (err_q == 4'd0);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign {DIN1, DIN2, DIN3} = din_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_q;
  assign FAIL_VEC = fvec_q;
  assign TOG_CNT  = tog_q;

endmodule
